// File: rtl/pipe_ctrl_unit.sv
// In-order core control unit: decodes the ID opcode, carries the control bundle
// through ID/EX, EX/MEM and MEM/WB, and inserts load-use bubbles with flush support.
module pipe_ctrl_unit #(
   parameter int OPCODE_W         = 7,
   parameter int REG_ADDR_W       = 5,
   parameter int LOAD_USE_BUBBLES = 1,
   parameter int STALL_CNT_W      = 16
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   valid_i,
   input  logic [OPCODE_W-1:0]    opcode_i,
   input  logic [REG_ADDR_W-1:0]  rs1_i,
   input  logic [REG_ADDR_W-1:0]  rs2_i,
   input  logic [REG_ADDR_W-1:0]  rd_i,
   input  logic                   flush_i,
   output logic                   stall_o,
   output logic                   ex_reg_dest_o,
   output logic                   ex_mem_read_o,
   output logic [REG_ADDR_W-1:0]  ex_rd_o,
   output logic                   mem_mem_read_o,
   output logic                   mem_mem_write_o,
   output logic                   mem_load_o,
   output logic                   mem_store_o,
   output logic                   wb_reg_write_o,
   output logic                   wb_mem_to_reg_o,
   output logic [REG_ADDR_W-1:0]  wb_rd_o,
   output logic                   illegal_o,
   output logic [STALL_CNT_W-1:0] stall_cnt_o
);

   typedef struct packed {
      logic reg_dest;
      logic mem_read;
      logic mem_to_reg;
      logic mem_write;
      logic reg_write;
      logic load;
      logic store;
   } ctrl_t;

   typedef struct packed {
      ctrl_t                 ctrl;
      logic [REG_ADDR_W-1:0] rd;
      logic                  illegal;
   } ex_stage_t;

   typedef struct packed {
      logic                  mem_read;
      logic                  mem_write;
      logic                  load;
      logic                  store;
      logic                  reg_write;
      logic                  mem_to_reg;
      logic [REG_ADDR_W-1:0] rd;
   } mem_stage_t;

   typedef struct packed {
      logic                  reg_write;
      logic                  mem_to_reg;
      logic [REG_ADDR_W-1:0] rd;
   } wb_stage_t;

   typedef enum logic {S_IDLE, S_STALL} state_t;

   localparam logic [OPCODE_W-1:0] OP_ALU   = OPCODE_W'(7'b0010011);
   localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(7'b0000011);
   localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(7'b0100011);
   localparam logic [OPCODE_W-1:0] OP_NOP   = '0;
   localparam logic [1:0]          CNT_INIT = 2'(LOAD_USE_BUBBLES - 1);
   localparam bit                  MULTI_BUBBLE = (LOAD_USE_BUBBLES > 1);

   ctrl_t                  id_ctrl;
   logic                   id_illegal, use_rs1, use_rs2, hz, stall;
   state_t                 state_q, state_d;
   logic [1:0]             cnt_q, cnt_d;
   ex_stage_t              ex_q, ex_d;
   mem_stage_t             mem_q, mem_d;
   wb_stage_t              wb_q, wb_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      id_ctrl    = '0;
      id_illegal = 1'b0;
      use_rs1    = 1'b0;
      use_rs2    = 1'b0;
      case (opcode_i)
         OP_ALU: begin
            id_ctrl.reg_dest  = 1'b1;
            id_ctrl.reg_write = 1'b1;
            use_rs1           = 1'b1;
         end
         OP_LOAD: begin
            id_ctrl.mem_read   = 1'b1;
            id_ctrl.mem_to_reg = 1'b1;
            id_ctrl.reg_write  = 1'b1;
            id_ctrl.load       = 1'b1;
            use_rs1            = 1'b1;
         end
         OP_STORE: begin
            id_ctrl.mem_write = 1'b1;
            id_ctrl.store     = 1'b1;
            use_rs1           = 1'b1;
            use_rs2           = 1'b1;
         end
         OP_NOP:  id_illegal = 1'b0;
         default: id_illegal = 1'b1;
      endcase
      if (rd_i == '0) id_ctrl.reg_write = 1'b0;
   end

   assign hz = valid_i && ex_q.ctrl.mem_read && (ex_q.rd != '0) &&
               ((use_rs1 && (rs1_i == ex_q.rd)) || (use_rs2 && (rs2_i == ex_q.rd)));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = 1'b0;
      case (state_q)
         S_IDLE: begin
            stall = hz && !flush_i;
            if (stall && MULTI_BUBBLE) begin
               state_d = S_STALL;
               cnt_d   = CNT_INIT;
            end
         end
         S_STALL: begin
            stall = !flush_i;
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // A flush aborts any stall sequence regardless of state.
      if (flush_i) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end
   end

   always_comb begin
      ex_d = '0;
      if (valid_i && !stall && !flush_i) begin
         ex_d.ctrl    = id_ctrl;
         ex_d.rd      = rd_i;
         ex_d.illegal = id_illegal;
      end
      mem_d = '{mem_read:   ex_q.ctrl.mem_read,  mem_write: ex_q.ctrl.mem_write,
                load:       ex_q.ctrl.load,      store:     ex_q.ctrl.store,
                reg_write:  ex_q.ctrl.reg_write, mem_to_reg: ex_q.ctrl.mem_to_reg,
                rd:         ex_q.rd};
      wb_d  = '{reg_write: mem_q.reg_write, mem_to_reg: mem_q.mem_to_reg, rd: mem_q.rd};
      stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + STALL_CNT_W'(1) : stall_cnt_q;
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_o         = stall;
   assign ex_reg_dest_o   = ex_q.ctrl.reg_dest;
   assign ex_mem_read_o   = ex_q.ctrl.mem_read;
   assign ex_rd_o         = ex_q.rd;
   assign illegal_o       = ex_q.illegal;
   assign mem_mem_read_o  = mem_q.mem_read;
   assign mem_mem_write_o = mem_q.mem_write;
   assign mem_load_o      = mem_q.load;
   assign mem_store_o     = mem_q.store;
   assign wb_reg_write_o  = wb_q.reg_write;
   assign wb_mem_to_reg_o = wb_q.mem_to_reg;
   assign wb_rd_o         = wb_q.rd;
   assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: three instances (1 bubble, 3 bubbles, 2-bit counter),
// directed vectors push cycle-stamped expectations that a negedge monitor consumes.
module tb_pipe_ctrl_unit;
   localparam int N = 3;
   localparam logic [6:0] OP_ALU = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_NOP = 7'b0000000;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   typedef enum int {SIG_STALL, SIG_EX_DEST, SIG_EX_MR, SIG_EX_RD, SIG_ILL,
                     SIG_MEM_MR, SIG_MEM_MW, SIG_MEM_LD, SIG_MEM_ST,
                     SIG_WB_RW, SIG_WB_M2R, SIG_WB_RD, SIG_CNT} sig_e;
   typedef struct {
      int          dut;
      int          cyc;
      sig_e        sig;
      int unsigned val;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   last   = 0;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic       valid_a [N];
   logic [6:0] op_a    [N];
   logic [4:0] rs1_a   [N];
   logic [4:0] rs2_a   [N];
   logic [4:0] rd_a    [N];
   logic       flush_a [N];

   wire        stall_w  [N];
   wire        exdest_w [N];
   wire        exmr_w   [N];
   wire [4:0]  exrd_w   [N];
   wire        memmr_w  [N];
   wire        memmw_w  [N];
   wire        memld_w  [N];
   wire        memst_w  [N];
   wire        wbrw_w   [N];
   wire        wbm2r_w  [N];
   wire [4:0]  wbrd_w   [N];
   wire        ill_w    [N];
   wire [15:0] cnt_w    [N];

   for (genvar g = 0; g < N; g++) begin : g_dut
      localparam int BUB = (g == 1) ? 3 : 1;
      localparam int CW  = (g == 2) ? 2 : 16;
      wire [CW-1:0] cnt;
      assign cnt_w[g] = 16'(cnt);
      pipe_ctrl_unit #(
         .OPCODE_W(7), .REG_ADDR_W(5), .LOAD_USE_BUBBLES(BUB), .STALL_CNT_W(CW)
      ) u_dut (
         .clk_i          (clk),
         .reset_n_i      (rst_n),
         .valid_i        (valid_a[g]),
         .opcode_i       (op_a[g]),
         .rs1_i          (rs1_a[g]),
         .rs2_i          (rs2_a[g]),
         .rd_i           (rd_a[g]),
         .flush_i        (flush_a[g]),
         .stall_o        (stall_w[g]),
         .ex_reg_dest_o  (exdest_w[g]),
         .ex_mem_read_o  (exmr_w[g]),
         .ex_rd_o        (exrd_w[g]),
         .mem_mem_read_o (memmr_w[g]),
         .mem_mem_write_o(memmw_w[g]),
         .mem_load_o     (memld_w[g]),
         .mem_store_o    (memst_w[g]),
         .wb_reg_write_o (wbrw_w[g]),
         .wb_mem_to_reg_o(wbm2r_w[g]),
         .wb_rd_o        (wbrd_w[g]),
         .illegal_o      (ill_w[g]),
         .stall_cnt_o    (cnt)
      );
   end

   function automatic logic [31:0] get(int d, sig_e s);
      case (s)
         SIG_STALL:   return {31'b0, stall_w[d]};
         SIG_EX_DEST: return {31'b0, exdest_w[d]};
         SIG_EX_MR:   return {31'b0, exmr_w[d]};
         SIG_EX_RD:   return {27'b0, exrd_w[d]};
         SIG_ILL:     return {31'b0, ill_w[d]};
         SIG_MEM_MR:  return {31'b0, memmr_w[d]};
         SIG_MEM_MW:  return {31'b0, memmw_w[d]};
         SIG_MEM_LD:  return {31'b0, memld_w[d]};
         SIG_MEM_ST:  return {31'b0, memst_w[d]};
         SIG_WB_RW:   return {31'b0, wbrw_w[d]};
         SIG_WB_M2R:  return {31'b0, wbm2r_w[d]};
         SIG_WB_RD:   return {27'b0, wbrd_w[d]};
         default:     return {16'b0, cnt_w[d]};
      endcase
   endfunction

   task automatic check(string name, int d, logic [31:0] act, int unsigned exp);
      checks++;
      if (act !== 32'(exp)) begin
         errors++;
         $display("FAIL %s dut%0d cyc%0d got %0h expected %0h", name, d, cyc, act, exp);
      end
   endtask

   // Scoreboard consumer: compares every expectation stamped with the current cycle.
   always @(negedge clk) begin
      int i;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].cyc == cyc) begin
            check(sb[i].sig.name(), sb[i].dut, get(sb[i].dut, sb[i].sig), sb[i].val);
            sb.delete(i);
         end else begin
            i++;
         end
      end
   end

   task automatic push(int d, int c, sig_e s, int unsigned v);
      exp_t e;
      e.dut = d; e.cyc = c; e.sig = s; e.val = v;
      sb.push_back(e);
   endtask

   task automatic issue(int d, int v, logic [6:0] op, int r1, int r2, int rd, int fl, int st);
      @(posedge clk); #1;
      valid_a[d] = v[0];
      op_a[d]    = op;
      rs1_a[d]   = 5'(r1);
      rs2_a[d]   = 5'(r2);
      rd_a[d]    = 5'(rd);
      flush_a[d] = fl[0];
      last       = cyc;
      push(d, last, SIG_STALL, st);
   endtask

   // ex2={reg_dest,mem_read}, mem4={mem_read,mem_write,load,store}, wb2={reg_write,mem_to_reg}
   task automatic expect_instr(int d, int ex2, int exrd, int ill, int mem4, int wb2, int wbrd);
      push(d, last + 1, SIG_EX_DEST, (ex2 >> 1) & 1);
      push(d, last + 1, SIG_EX_MR,   ex2 & 1);
      push(d, last + 1, SIG_EX_RD,   exrd);
      push(d, last + 1, SIG_ILL,     ill);
      push(d, last + 2, SIG_MEM_MR,  (mem4 >> 3) & 1);
      push(d, last + 2, SIG_MEM_MW,  (mem4 >> 2) & 1);
      push(d, last + 2, SIG_MEM_LD,  (mem4 >> 1) & 1);
      push(d, last + 2, SIG_MEM_ST,  mem4 & 1);
      push(d, last + 3, SIG_WB_RW,   (wb2 >> 1) & 1);
      push(d, last + 3, SIG_WB_M2R,  wb2 & 1);
      push(d, last + 3, SIG_WB_RD,   wbrd);
   endtask

   task automatic bubble(int d);
      expect_instr(d, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic push_zero_all();
      for (int d = 0; d < N; d++)
         for (int s = 0; s <= int'(SIG_CNT); s++) push(d, cyc, sig_e'(s), 0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      for (int d = 0; d < N; d++) begin
         valid_a[d] = 1'b0; op_a[d] = '0; rs1_a[d] = '0;
         rs2_a[d] = '0; rd_a[d] = '0; flush_a[d] = 1'b0;
      end
      push_zero_all();
      @(posedge clk); #1;
      push_zero_all();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc%0d got timeout expected finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      do_reset();

      // Mid-stream reset on the 1-bubble unit.
      issue(0, 1, OP_ALU, 1, 0, 3, 0, 0);
      push(0, last + 1, SIG_EX_DEST, 1);
      issue(0, 1, OP_LD, 2, 0, 4, 0, 0);
      do_reset();

      // Decode sweep, including illegal opcode and rd == x0.
      issue(0, 1, OP_ALU, 1, 0, 3, 0, 0); expect_instr(0, 2'b10, 3, 0, 4'b0000, 2'b10, 3);
      issue(0, 1, OP_LD,  2, 0, 4, 0, 0); expect_instr(0, 2'b01, 4, 0, 4'b1010, 2'b11, 4);
      issue(0, 1, OP_ST,  6, 7, 0, 0, 0); expect_instr(0, 2'b00, 0, 0, 4'b0101, 2'b00, 0);
      issue(0, 1, OP_NOP, 0, 0, 0, 0, 0); expect_instr(0, 2'b00, 0, 0, 4'b0000, 2'b00, 0);
      issue(0, 1, OP_BAD, 0, 0, 0, 0, 0); expect_instr(0, 2'b00, 0, 1, 4'b0000, 2'b00, 0);
      issue(0, 1, OP_ALU, 0, 0, 0, 0, 0); expect_instr(0, 2'b10, 0, 0, 4'b0000, 2'b00, 0);

      // Load-use with one bubble.
      issue(0, 1, OP_LD,  1, 0, 5, 0, 0); expect_instr(0, 2'b01, 5, 0, 4'b1010, 2'b11, 5);
      issue(0, 1, OP_ALU, 5, 0, 6, 0, 1); bubble(0);
      push(0, last, SIG_CNT, 0);
      issue(0, 1, OP_ALU, 5, 0, 6, 0, 0); expect_instr(0, 2'b10, 6, 0, 4'b0000, 2'b10, 6);
      push(0, last, SIG_CNT, 1); push(0, last + 1, SIG_CNT, 1);

      // Load to x0 never stalls the consumer.
      issue(0, 1, OP_LD,  1, 0, 0, 0, 0); expect_instr(0, 2'b01, 0, 0, 4'b1010, 2'b01, 0);
      issue(0, 1, OP_ALU, 0, 0, 6, 0, 0); expect_instr(0, 2'b10, 6, 0, 4'b0000, 2'b10, 6);

      // Matching registers with valid_i low: no stall, bubble enters EX.
      issue(0, 1, OP_LD,  1, 0, 5, 0, 0); expect_instr(0, 2'b01, 5, 0, 4'b1010, 2'b11, 5);
      issue(0, 0, OP_ALU, 5, 0, 6, 0, 0); bubble(0);

      // Back-to-back loads: only the load in EX is compared.
      issue(0, 1, OP_LD,  1, 0, 5, 0, 0); expect_instr(0, 2'b01, 5, 0, 4'b1010, 2'b11, 5);
      issue(0, 1, OP_LD,  2, 0, 6, 0, 0); expect_instr(0, 2'b01, 6, 0, 4'b1010, 2'b11, 6);
      issue(0, 1, OP_ALU, 6, 0, 7, 0, 1); bubble(0);
      issue(0, 1, OP_ALU, 6, 0, 7, 0, 0); expect_instr(0, 2'b10, 7, 0, 4'b0000, 2'b10, 7);
      push(0, last, SIG_CNT, 2);
      issue(0, 1, OP_LD,  1, 0, 5, 0, 0); expect_instr(0, 2'b01, 5, 0, 4'b1010, 2'b11, 5);
      issue(0, 1, OP_LD,  2, 0, 6, 0, 0); expect_instr(0, 2'b01, 6, 0, 4'b1010, 2'b11, 6);
      issue(0, 1, OP_ALU, 5, 0, 7, 0, 0); expect_instr(0, 2'b10, 7, 0, 4'b0000, 2'b10, 7);
      push(0, last + 1, SIG_CNT, 2);
      issue(0, 0, OP_NOP, 0, 0, 0, 0, 0); bubble(0);

      // Three bubbles: store's rs2 depends on the load.
      issue(1, 1, OP_LD, 1, 0, 5, 0, 0); expect_instr(1, 2'b01, 5, 0, 4'b1010, 2'b11, 5);
      issue(1, 1, OP_ST, 2, 5, 0, 0, 1); bubble(1); push(1, last, SIG_CNT, 0);
      issue(1, 1, OP_ST, 2, 5, 0, 0, 1); bubble(1); push(1, last, SIG_CNT, 1);
      issue(1, 1, OP_ST, 2, 5, 0, 0, 1); bubble(1); push(1, last, SIG_CNT, 2);
      issue(1, 1, OP_ST, 2, 5, 0, 0, 0); expect_instr(1, 2'b00, 0, 0, 4'b0101, 2'b00, 0);
      push(1, last, SIG_CNT, 3); push(1, last + 1, SIG_CNT, 3);

      // Flush in the second stall cycle.
      issue(1, 1, OP_LD,  1, 0, 7, 0, 0); expect_instr(1, 2'b01, 7, 0, 4'b1010, 2'b11, 7);
      issue(1, 1, OP_ALU, 7, 0, 8, 0, 1); bubble(1);
      issue(1, 1, OP_ALU, 7, 0, 8, 1, 0); bubble(1); push(1, last, SIG_CNT, 4);
      issue(1, 1, OP_ALU, 7, 0, 8, 0, 0); expect_instr(1, 2'b10, 8, 0, 4'b0000, 2'b10, 8);
      push(1, last, SIG_CNT, 4); push(1, last + 1, SIG_CNT, 4);

      // Flush together with a fresh hazard: no stall and no STALL entry.
      issue(1, 1, OP_LD,  1, 0, 9, 0, 0);  expect_instr(1, 2'b01, 9, 0, 4'b1010, 2'b11, 9);
      issue(1, 1, OP_ALU, 9, 0, 10, 1, 0); bubble(1);
      issue(1, 1, OP_ALU, 9, 0, 10, 0, 0); expect_instr(1, 2'b10, 10, 0, 4'b0000, 2'b10, 10);
      push(1, last + 1, SIG_CNT, 4);
      issue(1, 0, OP_NOP, 0, 0, 0, 0, 0); bubble(1);

      // Saturating 2-bit counter over five single-bubble hazards.
      for (int k = 1; k <= 5; k++) begin
         issue(2, 1, OP_LD,  1, 0, 5, 0, 0); expect_instr(2, 2'b01, 5, 0, 4'b1010, 2'b11, 5);
         issue(2, 1, OP_ALU, 5, 0, 6, 0, 1); bubble(2);
         issue(2, 1, OP_ALU, 5, 0, 6, 0, 0); expect_instr(2, 2'b10, 6, 0, 4'b0000, 2'b10, 6);
         push(2, last, SIG_CNT, (k > 3) ? 3 : k);
      end
      issue(2, 0, OP_NOP, 0, 0, 0, 0, 0); bubble(2);
      push(2, last + 1, SIG_CNT, 3);

      for (int n = 0; n < 20 && sb.size() > 0; n++) @(posedge clk);
      #1;
      foreach (sb[i]) begin
         checks++;
         errors++;
         $display("FAIL %s dut%0d cyc%0d got unchecked expected checked", sb[i].sig.name(), sb[i].dut, sb[i].cyc);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
